// File: rtl/seg_share_pkg.sv
// Shared types and constants for the segment-share arbiter.
// Holds the FSM state enum, default parameter values and counter-width helpers.
package seg_share_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_e;

  localparam int unsigned DEF_NUM_REQ     = 2;
  localparam int unsigned DEF_SEG_W       = 8;
  localparam int unsigned DEF_HOLD_CYCLES = 8;
  localparam int unsigned DEF_MAX_CYCLES  = 64;

  // Width of a counter that must be able to hold max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index into n requesters (at least 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at last_owner+1 (wrapping) and returns the first hit.
//   req        in   NUM_REQ  current request vector
//   last_owner in   IW       index of the most recent owner
//   onehot     out  NUM_REQ  one-hot winner (zero when none)
//   idx        out  IW       winner index
//   valid      out  1        a winner exists
module rr_pick
  import seg_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IW      = idx_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  always_comb begin
    int unsigned c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      c = (32'(last_owner) + k) % NUM_REQ;
      if (!valid && req[IW'(c)]) begin
        valid          = 1'b1;
        idx            = IW'(c);
        onehot[IW'(c)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin arbiter sharing one segment/LED output bank between requesters,
// with registered one-hot grant, minimum tenure and a one-cycle blanking gap.
// Optional feature macro: SEG_SHARE_TIMEOUT_EN (forced release at MAX_CYCLES).
//   clk       in   1                rising-edge clock
//   rst       in   1                asynchronous active-high reset
//   req       in   NUM_REQ          level request per source
//   seg_in    in   NUM_REQ*SEG_W    source i at [i*SEG_W +: SEG_W]
//   gnt       out  NUM_REQ          registered one-hot grant
//   seg_out   out  SEG_W            registered segment output
//   busy      out  1                high in GRANT or GAP
//   timeout_o out  1                forced-release pulse (macro builds only)
module seg_share_arbiter
  import seg_share_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned SEG_W       = DEF_SEG_W,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEG_W-1:0] seg_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEG_W-1:0]         seg_out,
  output logic                     busy
`ifdef SEG_SHARE_TIMEOUT_EN
  ,
  output logic                     timeout_o
`endif
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned HW = cnt_w(HOLD_CYCLES);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [HW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [SEG_W-1:0]   owner_seg;
  logic [HW-1:0]      cnt_inc;
  logic               owner_req, other_req, release_now;

`ifdef SEG_SHARE_TIMEOUT_EN
  localparam int unsigned TW = cnt_w(MAX_CYCLES);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q, timeout_d;
  logic          force_now;
`endif

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req       (req),
    .last_owner(last_q),
    .onehot    (pick_onehot),
    .idx       (pick_idx),
    .valid     (pick_valid)
  );

  // Mux keyed on the registered grant so only the owner can reach seg_out.
  always_comb begin
    owner_seg = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) owner_seg = owner_seg | seg_in[i*SEG_W +: SEG_W];
    end
  end

  assign owner_req = |(req & gnt_q);
  assign other_req = |(req & ~gnt_q);
  assign cnt_inc   = (cnt_q == HW'(HOLD_CYCLES)) ? cnt_q : cnt_q + 1'b1;

  // Hold test uses the incremented count so the tenure is exactly HOLD_CYCLES.
  assign release_now = (cnt_inc == HW'(HOLD_CYCLES)) && (!owner_req || other_req);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef SEG_SHARE_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    force_now = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        seg_d = '0;
        if (pick_valid) begin
          state_d = S_GRANT;
          gnt_d   = pick_onehot;
          cnt_d   = '0;
          last_d  = pick_idx;
`ifdef SEG_SHARE_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_GRANT: begin
        cnt_d = cnt_inc;
        seg_d = owner_seg;
`ifdef SEG_SHARE_TIMEOUT_EN
        tcnt_d    = tcnt_q + 1'b1;
        force_now = (tcnt_d == TW'(MAX_CYCLES));
        timeout_d = force_now && !release_now;
        if (release_now || force_now) begin
`else
        if (release_now) begin
`endif
          state_d = S_GAP;
          gnt_d   = '0;
          seg_d   = '0;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        seg_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        seg_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

`ifdef SEG_SHARE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  assign gnt     = gnt_q;
  assign seg_out = seg_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed self-checking bench for seg_share_arbiter (NUM_REQ=2, SEG_W=8,
// HOLD_CYCLES=8, MAX_CYCLES=64).
module tb_seg_share_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] seg_in;
  logic [1:0]  gnt;
  logic [7:0]  seg_out;
  logic        busy;
`ifdef SEG_SHARE_TIMEOUT_EN
  logic        timeout_o;
`endif

  int unsigned n_chk;
  int unsigned n_bad;

  seg_share_arbiter #(
    .NUM_REQ    (2),
    .SEG_W      (8),
    .HOLD_CYCLES(8),
    .MAX_CYCLES (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .seg_in   (seg_in),
    .gnt      (gnt),
    .seg_out  (seg_out),
    .busy     (busy)
`ifdef SEG_SHARE_TIMEOUT_EN
    ,
    .timeout_o(timeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    tick();
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_seg", 32'(seg_out), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    req    = 2'b00;
    seg_in = {8'hAA, 8'h3F};

    // Single requester, then a competitor arrives at grant cycle 2.
    do_reset();
    req = 2'b01;
    tick();
    check_eq("a_gnt_lat", 32'(gnt), 32'h1);
    check_eq("a_seg_lat0", 32'(seg_out), 32'h0);
    check_eq("a_busy", 32'(busy), 32'h1);
    tick();
    check_eq("a_seg_lat1", 32'(seg_out), 32'h3F);
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("a_hold_gnt", 32'(gnt), 32'h1);
    end
    tick();
    check_eq("a_gap_gnt", 32'(gnt), 32'h0);
    check_eq("a_gap_seg", 32'(seg_out), 32'h0);
    check_eq("a_gap_busy", 32'(busy), 32'h1);
    tick();
    check_eq("a_idle_gnt", 32'(gnt), 32'h0);
    check_eq("a_idle_busy", 32'(busy), 32'h0);
    tick();
    check_eq("a_next_gnt", 32'(gnt), 32'h2);
    check_eq("a_next_seg0", 32'(seg_out), 32'h0);
    tick();
    check_eq("a_next_seg1", 32'(seg_out), 32'hAA);

    // Both requesting from reset: strict alternation, 8-cycle tenures.
    do_reset();
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        check_eq("b_tenure", 32'(gnt), (t % 2 == 0) ? 32'h1 : 32'h2);
      end
      tick();
      check_eq("b_gap", 32'(gnt), 32'h0);
      check_eq("b_gap_busy", 32'(busy), 32'h1);
      tick();
      check_eq("b_idle", 32'(gnt), 32'h0);
    end

    // Owner drops early: grant held to full tenure, seg keeps following owner.
    do_reset();
    req = 2'b01;
    tick();
    tick();
    tick();
    req    = 2'b00;
    seg_in = {8'hAA, 8'h5B};
    tick();
    check_eq("c_follow_seg", 32'(seg_out), 32'h5B);
    check_eq("c_hold_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("c_hold_gnt", 32'(gnt), 32'h1);
    end
    tick();
    check_eq("c_gap_gnt", 32'(gnt), 32'h0);
    check_eq("c_gap_seg", 32'(seg_out), 32'h0);
    check_eq("c_gap_busy", 32'(busy), 32'h1);
    tick();
    check_eq("c_idle_busy", 32'(busy), 32'h0);
    tick();
    check_eq("c_stay_gnt", 32'(gnt), 32'h0);
    check_eq("c_stay_busy", 32'(busy), 32'h0);

    // Asynchronous reset in mid-grant, then pointer restart.
    do_reset();
    req = 2'b01;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("d_async_gnt", 32'(gnt), 32'h0);
    check_eq("d_async_seg", 32'(seg_out), 32'h0);
    check_eq("d_async_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    req = 2'b11;
    tick();
    check_eq("d_ptr_both", 32'(gnt), 32'h1);
    do_reset();
    req = 2'b10;
    tick();
    check_eq("d_ptr_req1", 32'(gnt), 32'h2);

    // Lone owner holding request.
    do_reset();
    req = 2'b01;
`ifdef SEG_SHARE_TIMEOUT_EN
    for (int i = 0; i < 64; i++) begin
      tick();
      check_eq("e_long_gnt", 32'(gnt), 32'h1);
      check_eq("e_no_to", 32'(timeout_o), 32'h0);
    end
    tick();
    check_eq("e_to_pulse", 32'(timeout_o), 32'h1);
    check_eq("e_to_gap", 32'(gnt), 32'h0);
    tick();
    check_eq("e_to_clear", 32'(timeout_o), 32'h0);
    check_eq("e_to_idle", 32'(gnt), 32'h0);
    tick();
    check_eq("e_regrant", 32'(gnt), 32'h1);
`else
    for (int i = 0; i < 70; i++) begin
      tick();
      check_eq("e_long_gnt", 32'(gnt), 32'h1);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
